// File: rtl/tli4970_sensor_scheduler.sv
// rtl/tli4970_sensor_scheduler.sv - round-robin TLI4970 sensor scheduler over one shared SPI frame controller
// Optional build macro TLI4970_PARITY_CHECK_EN adds the parity check on captured words.

module tli4970_sensor_scheduler #(
   parameter int NUM_SENSORS    = 4,
   parameter int SETTLE_CYCLES  = 8,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [31:0]               period,
   output logic                      spi_start,
   input  logic                      spi_done,
   input  logic [15:0]               spi_word,
   output logic [NUM_SENSORS-1:0]    sensor_sel,
   output logic [NUM_SENSORS*16-1:0] currents,
   output logic [NUM_SENSORS-1:0]    valid,
   output logic [NUM_SENSORS-1:0]    ocd,
   output logic [NUM_SENSORS-1:0]    err,
   output logic                      round_done
);

   localparam int IDXW    = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
   localparam int CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [IDXW-1:0] LAST_IDX    = IDXW'(NUM_SENSORS - 1);
   localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0]   TMO_LAST    = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_START,
      S_BUSY,
      S_CAPTURE,
      S_NEXT
   } state_t;

   state_t                    state_q, state_d;
   logic [IDXW-1:0]           idx_q, idx_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [31:0]               per_q, per_d;
   logic [NUM_SENSORS*16-1:0] cur_q, cur_d;
   logic [NUM_SENSORS-1:0]    valid_q, valid_d;
   logic [NUM_SENSORS-1:0]    ocd_q, ocd_d;
   logic [NUM_SENSORS-1:0]    err_q, err_d;

   logic [NUM_SENSORS-1:0]    idx_mask;
   logic                      tmo_hit;
   logic                      tmo_fire;
   logic                      word_bad;
   logic [15:0]               cur_val;

   assign idx_mask = NUM_SENSORS'(1) << idx_q;
   assign tmo_hit  = (cnt_q == TMO_LAST);
   assign tmo_fire = tmo_hit && (((state_q == S_START) && spi_done) ||
                                 ((state_q == S_BUSY) && !spi_done));

   // The 13-bit field is offset-binary around 4096.
   assign cur_val = {3'b000, spi_word[12:0]} - 16'd4096;

`ifdef TLI4970_PARITY_CHECK_EN
   // Bit 14 makes the whole word even parity; an odd total means a corrupted frame.
   assign word_bad = spi_word[15] | (^spi_word);
`else
   logic unused_parity_bit;
   assign unused_parity_bit = spi_word[14];
   assign word_bad          = spi_word[15];
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (enable && (per_q == 32'd0)) state_d = S_SELECT;
         end
         S_SELECT: begin
            if (cnt_q == SETTLE_LAST) state_d = S_START;
         end
         S_START: begin
            if (!spi_done)    state_d = S_BUSY;
            else if (tmo_hit) state_d = S_NEXT;
         end
         S_BUSY: begin
            if (spi_done)     state_d = S_CAPTURE;
            else if (tmo_hit) state_d = S_NEXT;
         end
         S_CAPTURE: state_d = S_NEXT;
         S_NEXT:    state_d = (idx_q == LAST_IDX) ? S_IDLE : S_SELECT;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      spi_start  = (state_q == S_START);
      sensor_sel = '0;
      if (state_q inside {S_SELECT, S_START, S_BUSY, S_CAPTURE}) sensor_sel = idx_mask;
      round_done = (state_q == S_NEXT) && (idx_q == LAST_IDX);
      currents   = cur_q;
      valid      = valid_q;
      ocd        = ocd_q;
      err        = err_q;
   end

   always_comb begin
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      per_d   = (per_q != 32'd0) ? per_q - 32'd1 : 32'd0;
      cur_d   = cur_q;
      valid_d = valid_q;
      ocd_d   = ocd_q;
      err_d   = err_q;

      // One counter times both the settle window and the START+BUSY timeout.
      if ((state_d != state_q) && ((state_d == S_SELECT) || (state_d == S_START))) begin
         cnt_d = '0;
      end else if (state_q inside {S_SELECT, S_START, S_BUSY}) begin
         cnt_d = cnt_q + 1'b1;
      end

      if ((state_q == S_IDLE) && (state_d == S_SELECT)) begin
         idx_d = '0;
         per_d = (period == 32'd0) ? 32'd0 : period - 32'd1;
      end

      if ((state_q == S_NEXT) && (state_d == S_SELECT)) begin
         idx_d = idx_q + 1'b1;
      end

      if (state_q == S_CAPTURE) begin
         if (word_bad) begin
            err_d = err_q | idx_mask;
         end else begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
               if (idx_mask[i]) cur_d[i*16 +: 16] = cur_val;
            end
            valid_d = valid_q | idx_mask;
            ocd_d   = spi_word[13] ? (ocd_q | idx_mask) : (ocd_q & ~idx_mask);
         end
      end

      if (tmo_fire) begin
         err_d = err_q | idx_mask;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         idx_q   <= '0;
         cnt_q   <= '0;
         per_q   <= 32'd0;
         cur_q   <= '0;
         valid_q <= '0;
         ocd_q   <= '0;
         err_q   <= '0;
      end else begin
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         per_q   <= per_d;
         cur_q   <= cur_d;
         valid_q <= valid_d;
         ocd_q   <= ocd_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_tli4970_sensor_scheduler.sv
// tb/tb_tli4970_sensor_scheduler.sv - randomized self-checking bench for tli4970_sensor_scheduler
// A behavioural frame model answers each start; a per-sensor result model is checked at every round end.

module tb_tli4970_sensor_scheduler;

   localparam int N      = 4;
   localparam int SETTLE = 8;
   localparam int TMO    = 300;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic            enable = 1'b0;
   logic [31:0]     period = 32'd0;
   logic            spi_start;
   logic            spi_done = 1'b1;
   logic [15:0]     spi_word = 16'h0000;
   logic [N-1:0]    sensor_sel;
   logic [N*16-1:0] currents;
   logic [N-1:0]    valid;
   logic [N-1:0]    ocd;
   logic [N-1:0]    err;
   logic            round_done;

   tli4970_sensor_scheduler #(
      .NUM_SENSORS   (N),
      .SETTLE_CYCLES (SETTLE),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
      .period    (period),
      .spi_start (spi_start),
      .spi_done  (spi_done),
      .spi_word  (spi_word),
      .sensor_sel(sensor_sel),
      .currents  (currents),
      .valid     (valid),
      .ocd       (ocd),
      .err       (err),
      .round_done(round_done)
   );

   always #10 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference result bank, expressed directly from the word-decoding rules.
   int          exp_cur[N];
   bit          exp_valid[N];
   bit          exp_ocd[N];
   bit          exp_err[N];
   logic [15:0] resp[N];
   bit          hang[N];
   bit          in_busy = 0;
   int          busy_s = 0;

   function automatic void model_clear();
      for (int i = 0; i < N; i++) begin
         exp_cur[i]   = 0;
         exp_valid[i] = 0;
         exp_ocd[i]   = 0;
         exp_err[i]   = 0;
      end
   endfunction

   function automatic void apply_word(int s, logic [15:0] w);
      bit bad;
      bad = w[15];
`ifdef TLI4970_PARITY_CHECK_EN
      if (($countones(w) % 2) == 1) bad = 1;
`endif
      if (bad) begin
         exp_err[s] = 1;
      end else begin
         exp_cur[s]   = int'(w[12:0]) - 4096;
         exp_ocd[s]   = w[13];
         exp_valid[s] = 1;
      end
   endfunction

   function automatic int sel2idx(logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return 0;
   endfunction

   // Frame controller model: accept a start, stay busy a random time, then present the word.
   initial begin
      int s;
      int lat;
      forever begin
         @(posedge clock);
         #1;
         if (!reset && spi_start && spi_done) begin
            s = sel2idx(sensor_sel);
            if (hang[s]) begin
               exp_err[s] = 1;
            end else begin
               spi_done = 1'b0;
               busy_s   = s;
               in_busy  = 1;
               lat      = $urandom_range(2, 6);
               repeat (lat) begin
                  @(posedge clock);
                  #1;
                  if (reset) break;
               end
               if (!reset) begin
                  spi_word = resp[s];
                  apply_word(s, resp[s]);
               end
               spi_done = 1'b1;
               in_busy  = 0;
            end
         end
      end
   end

   // Monitor state
   int           cyc = 0;
   int           exp_idx = 0;
   int           cur_s = 0;
   int           settle_cnt = 0;
   int           st_cnt = 0;
   int           rd_count = 0;
   int           start_samples = 0;
   int           last_r0 = -1;
   bit           spacing_on = 0;
   bit           seen_start = 0;
   logic [N-1:0] prev_sel = '0;
   logic         prev_start = 1'b0;

   task automatic check_results();
      for (int s = 0; s < N; s++) begin
         check($sformatf("cur%0d", s), {48'h0, currents[s*16 +: 16]}, 64'(exp_cur[s] & 32'hFFFF));
         check($sformatf("valid%0d", s), valid[s], exp_valid[s]);
         check($sformatf("ocd%0d", s), ocd[s], exp_ocd[s]);
         check($sformatf("err%0d", s), err[s], exp_err[s]);
      end
   endtask

   task automatic monitor();
      if (prev_start && !spi_start) begin
         if (hang[cur_s]) check("tmo_start_len", st_cnt, TMO);
         st_cnt = 0;
      end
      if (spi_start) begin
         st_cnt++;
         start_samples++;
      end
      if ((sensor_sel != '0) && (prev_sel == '0)) begin
         check("sel_order", sensor_sel, 64'(1) << exp_idx);
         cur_s      = exp_idx;
         exp_idx++;
         settle_cnt = 0;
         seen_start = 0;
         if (sensor_sel == 1) begin
            if (spacing_on && last_r0 >= 0) check("round_spacing", cyc - last_r0, 1000);
            last_r0 = cyc;
         end
      end
      if ((sensor_sel != '0) && !spi_start && !seen_start) settle_cnt++;
      if (spi_start && !prev_start) begin
         check("settle", settle_cnt, SETTLE);
         seen_start = 1;
      end
      if (round_done) begin
         rd_count++;
         check("round_sensors", exp_idx, N);
         check_results();
         exp_idx = 0;
      end
      prev_sel   = sensor_sel;
      prev_start = spi_start;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
      monitor();
   endtask

   task automatic wait_rounds(input int n, input int budget);
      int target;
      int k;
      target = rd_count + n;
      k = 0;
      while (rd_count < target && k < budget) begin
         tick();
         k++;
      end
      if (rd_count < target) check("round_wait_timeout", rd_count, target);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_sel"}, sensor_sel, 0);
      check({tag, "_start"}, spi_start, 0);
      check({tag, "_cur"}, currents, 0);
      check({tag, "_valid"}, valid, 0);
      check({tag, "_ocd"}, ocd, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_rdone"}, round_done, 0);
   endtask

   initial begin
      int k;
      int rd0;
      model_clear();
      for (int i = 0; i < N; i++) begin
         resp[i] = 16'h1064;
         hang[i] = 0;
      end

      repeat (3) tick();
      check_all_zero("reset");

      // Fixed 0x1064 from every sensor at a 1000-clock period.
      period = 32'd1000;
      enable = 1'b1;
      #2;
      reset = 1'b0;
      spacing_on = 1;
      wait_rounds(3, 4000);
      spacing_on = 0;
      for (int s = 0; s < N; s++) check($sformatf("p1_cur%0d", s), currents[s*16 +: 16], 16'h0064);
      check("p1_valid", valid, 4'hF);
      check("p1_ocd", ocd, 4'h0);
      check("p1_err", err, 4'h0);

      // Sensor 2 never answers: it times out and the round still finishes.
      hang[2] = 1;
      wait_rounds(1, 2500);
      check("hang_err", err, 4'b0100);
      check("hang_cur2", currents[47:32], 16'h0064);
      hang[2] = 0;

      // Directed decode corners, then back-to-back random rounds.
      period  = 32'd0;
      resp[0] = 16'h2000;
      resp[1] = 16'h0FFF;
      resp[2] = 16'h3000;
      resp[3] = 16'h8123;
      wait_rounds(1, 2500);
      check("dir_cur0", currents[15:0], 16'hF000);
      check("dir_ocd0", ocd[0], 1'b1);
      check("dir_cur1", currents[31:16], 16'hFFFF);
      check("dir_ocd1", ocd[1], 1'b0);
      check("dir_cur2", currents[47:32], 16'h0000);
      check("dir_cur3_kept", currents[63:48], 16'h0064);
      check("dir_err3", err[3], 1'b1);

      for (int r = 0; r < 6; r++) begin
         for (int s = 0; s < N; s++) resp[s] = 16'($urandom_range(0, 65535));
         wait_rounds(1, 1000);
      end

      // Reset while sensor 1 is in its busy phase.
      for (int s = 0; s < N; s++) resp[s] = 16'($urandom_range(0, 32767));
      k = 0;
      while (k < 2000) begin
         tick();
         #2;
         if (in_busy && busy_s == 1 && !spi_start) break;
         k++;
      end
      if (k >= 2000) check("busy1_wait_timeout", k, 0);
      reset = 1'b1;
      #1;
      check_all_zero("midreset");
      model_clear();
      exp_idx    = 0;
      st_cnt     = 0;
      seen_start = 0;
      repeat (2) tick();
      #2;
      reset = 1'b0;
      wait_rounds(1, 1000);

      // Drop enable while sensor 1 is selected: the round still completes, then nothing.
      k = 0;
      while (sensor_sel != 4'b0010 && k < 1000) begin
         tick();
         k++;
      end
      if (k >= 1000) check("sel1_wait_timeout", k, 0);
      enable = 1'b0;
      rd0 = rd_count;
      wait_rounds(1, 1000);
      start_samples = 0;
      repeat (200) tick();
      check("no_start_after_disable", start_samples, 0);
      check("single_round_done", rd_count, rd0 + 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
